// File: rtl/countdown_timer.sv
// countdown_timer: programmable down-counter with terminal-count signalling.
// Loaded with a value, it counts down to zero once started and then flags
// completion. In periodic mode it reloads and keeps running, so it can serve
// as either a timeout or a periodic tick source.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   load_i         load strobe; captures load_val_i into count and reload register
//   load_val_i     load value (WIDTH bits)
//   start_i        start/restart strobe
//   stop_i         stop strobe; halts a running count and holds cnt_o
//   auto_reload_i  level; 1 = periodic mode (sampled at the terminal edge only)
//   cnt_o          current count (registered)
//   busy_o         high while counting
//   tc_o           one-cycle terminal-count pulse (registered)
//   flag           high while in the completed state (sticky until load/start)
//
// Strobe priority on each edge: load_i > stop_i > start_i.

module countdown_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             busy_o,
    output logic             tc_o,
    output logic             flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    // Start is honoured only when no higher-priority strobe is present.
    logic start_ok;
    assign start_ok = start_i && !stop_i;

    // Status levels decoded straight from the state register.
    assign busy_o = (state == RUN);
    assign flag   = (state == DONE);

    // State, count, reload register and terminal-count pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt_o      <= '0;
            reload_reg <= '0;
            tc_o       <= 1'b0;
        end else begin
            tc_o <= 1'b0;
            if (load_i) begin
                // Load aborts any count in progress without a terminal pulse.
                cnt_o      <= load_val_i;
                reload_reg <= load_val_i;
                state      <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_ok) begin
                            if (cnt_o != '0) begin
                                state <= RUN;
                            end else begin
                                // Nothing to count: complete immediately.
                                tc_o  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                    RUN: begin
                        if (stop_i) begin
                            state <= IDLE;
                        end else if (cnt_o > WIDTH'(1)) begin
                            cnt_o <= cnt_o - WIDTH'(1);
                        end else begin
                            // Terminal edge; auto_reload_i only matters here.
                            tc_o <= 1'b1;
                            if (auto_reload_i) begin
                                cnt_o <= reload_reg;
                            end else begin
                                cnt_o <= '0;
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (start_ok) begin
                            if (reload_reg != '0) begin
                                cnt_o <= reload_reg;
                                state <= RUN;
                            end else begin
                                tc_o <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic             start_i;
    logic             stop_i;
    logic             auto_reload_i;
    logic [WIDTH-1:0] cnt_o;
    logic             busy_o;
    logic             tc_o;
    logic             flag;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_i        (load_i),
        .load_val_i    (load_val_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .auto_reload_i (auto_reload_i),
        .cnt_o         (cnt_o),
        .busy_o        (busy_o),
        .tc_o          (tc_o),
        .flag          (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic             busy;
        logic             tc;
        logic             flg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".cnt"},  32'(cnt_o),  32'(e.cnt));
        chk({tag, ".busy"}, 32'(busy_o), 32'(e.busy));
        chk({tag, ".tc"},   32'(tc_o),   32'(e.tc));
        chk({tag, ".flag"}, 32'(flag),   32'(e.flg));
    endtask

    // One clock cycle: drive strobes at negedge, queue the expected outputs,
    // then compare just after the following rising edge.
    task automatic cyc(input logic ld, input logic [WIDTH-1:0] v, input logic st,
                       input logic sp, input logic ar,
                       input logic [WIDTH-1:0] ec, input logic eb, input logic et,
                       input logic ef, input string tag);
        exp_t e;
        @(negedge clk);
        load_i        = ld;
        load_val_i    = v;
        start_i       = st;
        stop_i        = sp;
        auto_reload_i = ar;
        e.cnt = ec; e.busy = eb; e.tc = et; e.flg = ef;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            chk_all(tag, sb.pop_front());
        end
    endtask

    task automatic idle(input logic ar, input logic [WIDTH-1:0] ec, input logic eb,
                        input logic et, input logic ef, input string tag);
        cyc(1'b0, '0, 1'b0, 1'b0, ar, ec, eb, et, ef, tag);
    endtask

    initial begin
        exp_t z;
        z.cnt = '0; z.busy = 1'b0; z.tc = 1'b0; z.flg = 1'b0;
        load_i = 0; load_val_i = '0; start_i = 0; stop_i = 0; auto_reload_i = 0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1 chk_all("reset_assert", z);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) idle(0, 8'd0, 0, 0, 0, "idle_after_reset");

        // One-shot count of 5, then restart from DONE
        cyc(1, 8'd5, 0, 0, 0, 8'd5, 0, 0, 0, "load5");
        cyc(0, 8'd0, 1, 0, 0, 8'd5, 1, 0, 0, "start5");
        for (int i = 4; i >= 1; i--) idle(0, WIDTH'(i), 1, 0, 0, "count5");
        idle(0, 8'd0, 0, 1, 1, "tc5");
        idle(0, 8'd0, 0, 0, 1, "done5_hold");
        cyc(0, 8'd0, 1, 0, 0, 8'd5, 1, 0, 0, "restart_done");
        for (int i = 4; i >= 1; i--) idle(0, WIDTH'(i), 1, 0, 0, "recount5");
        idle(0, 8'd0, 0, 1, 1, "retc5");

        // Periodic mode with reload 3
        cyc(1, 8'd3, 0, 0, 1, 8'd3, 0, 0, 0, "load3");
        cyc(0, 8'd0, 1, 0, 1, 8'd3, 1, 0, 0, "start3");
        for (int i = 0; i < 10; i++) begin
            int r;
            r = (i + 1) % 3;
            idle(1, (r == 0) ? 8'd3 : WIDTH'(3 - r), 1, (r == 0), 0, "periodic3");
        end
        idle(0, 8'd1, 1, 0, 0, "periodic_off");
        idle(0, 8'd0, 0, 1, 1, "periodic_end");

        // Stop / resume
        cyc(1, 8'd6, 0, 0, 0, 8'd6, 0, 0, 0, "load6");
        cyc(0, 8'd0, 1, 0, 0, 8'd6, 1, 0, 0, "start6");
        idle(0, 8'd5, 1, 0, 0, "dec6a");
        idle(0, 8'd4, 1, 0, 0, "dec6b");
        cyc(0, 8'd0, 0, 1, 0, 8'd4, 0, 0, 0, "stop6");
        for (int i = 0; i < 4; i++) idle(0, 8'd4, 0, 0, 0, "hold4");
        cyc(0, 8'd0, 1, 0, 0, 8'd4, 1, 0, 0, "resume4");
        for (int i = 3; i >= 1; i--) idle(0, WIDTH'(i), 1, 0, 0, "count_resume");
        idle(0, 8'd0, 0, 1, 1, "tc_resume");

        // Stop and start in the same RUN cycle: stop wins
        cyc(1, 8'd6, 0, 0, 0, 8'd6, 0, 0, 0, "load6b");
        cyc(0, 8'd0, 1, 0, 0, 8'd6, 1, 0, 0, "start6b");
        idle(0, 8'd5, 1, 0, 0, "dec6c");
        cyc(0, 8'd0, 1, 1, 0, 8'd5, 0, 0, 0, "stop_start_same");
        idle(0, 8'd5, 0, 0, 0, "stop_wins_hold");

        // Load 0 then start: immediate terminal pulse, no RUN
        cyc(1, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0, "load0");
        cyc(0, 8'd0, 1, 0, 0, 8'd0, 0, 1, 1, "start0");
        idle(0, 8'd0, 0, 0, 1, "done0_hold");
        cyc(0, 8'd0, 1, 0, 0, 8'd0, 0, 1, 1, "restart0_done");

        // Reload 1 in periodic mode: tc every cycle
        cyc(1, 8'd1, 0, 0, 1, 8'd1, 0, 0, 0, "load1");
        cyc(0, 8'd0, 1, 0, 1, 8'd1, 1, 0, 0, "start1");
        for (int i = 0; i < 5; i++) idle(1, 8'd1, 1, 1, 0, "periodic1");
        idle(0, 8'd0, 0, 1, 1, "periodic1_end");

        // Full-scale count of 255
        cyc(1, 8'd255, 0, 0, 0, 8'd255, 0, 0, 0, "load255");
        cyc(0, 8'd0, 1, 0, 0, 8'd255, 1, 0, 0, "start255");
        for (int i = 254; i >= 1; i--) idle(0, WIDTH'(i), 1, 0, 0, "count255");
        idle(0, 8'd0, 0, 1, 1, "tc255");
        idle(0, 8'd0, 0, 0, 1, "done255_hold");

        // Async reset between edges while counting at 7
        cyc(1, 8'd10, 0, 0, 0, 8'd10, 0, 0, 0, "load10");
        cyc(0, 8'd0, 1, 0, 0, 8'd10, 1, 0, 0, "start10");
        for (int i = 9; i >= 7; i--) idle(0, WIDTH'(i), 1, 0, 0, "count10");
        #2 reset = 1'b1;
        #1 chk_all("async_reset_midcount", z);
        @(posedge clk);
        #1 chk_all("reset_held_edge", z);
        @(negedge clk) reset = 1'b0;

        // Load during RUN aborts with no terminal pulse
        cyc(1, 8'd8, 0, 0, 0, 8'd8, 0, 0, 0, "load8");
        cyc(0, 8'd0, 1, 0, 0, 8'd8, 1, 0, 0, "start8");
        idle(0, 8'd7, 1, 0, 0, "dec8");
        cyc(1, 8'd20, 0, 0, 0, 8'd20, 0, 0, 0, "load_in_run");
        idle(0, 8'd20, 0, 0, 0, "after_load_in_run");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
